// File: rtl/wb_write_sequencer.sv
// wb_write_sequencer: splits a W-stage entry into at most two register-file writes (E then M).
// Latency: rf_* valid one cycle after the W entry is sampled; a dual write occupies two cycles.
// Backpressure: W_stall holds the W register for a pending second write and permanently after a fault.
// Optional feature macro WB_PERF_CNT_EN adds retired_cnt / dual_stall_cnt.
module wb_write_sequencer #(
  parameter int          DATA_W = 64,
`ifdef WB_PERF_CNT_EN
  parameter int          CNT_W  = 32,
`endif
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        W_stat,
  input  logic [3:0]        W_icode,
  input  logic              W_Cnd,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  output logic              W_stall,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        proc_stat,
  output logic              halted
`ifdef WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  dual_stall_cnt
`endif
);

  localparam logic [2:0] SBUB  = 3'd0;
  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [3:0] ICMOV = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SECOND = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [3:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [2:0]        proc_stat_q, proc_stat_d;
  logic              halted_q, halted_d;

  logic e_vld, m_vld, same_dst, dual_wr, fault_entry, normal_op;

  // Write-intent decode for the entry currently in W; a failed cmov drops its E write.
  always_comb begin
    e_vld       = (W_dstE != RNONE) && !((W_icode == ICMOV) && !W_Cnd);
    m_vld       = (W_dstM != RNONE);
    same_dst    = e_vld && m_vld && (W_dstE == W_dstM);
    dual_wr     = e_vld && m_vld && !same_dst;
    fault_entry = (W_stat != SBUB) && (W_stat != SAOK);
    normal_op   = (W_stat == SAOK);
  end

  // Stall W while a dual write is issuing its first half, and forever once halted.
  // Held low during reset so the pipeline is never frozen by a stale entry.
  always_comb begin
    W_stall = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE:   W_stall = normal_op && dual_wr;
        ST_SECOND: W_stall = 1'b0;
        ST_HALT:   W_stall = 1'b1;
        default:   W_stall = 1'b0;
      endcase
    end
  end

  // Next-state and next-output selection; address/data hold when no write is issued.
  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    proc_stat_d = proc_stat_q;
    halted_d    = halted_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fault_entry) begin
          proc_stat_d = W_stat;
          halted_d    = 1'b1;
          state_d     = ST_HALT;
        end else if (normal_op) begin
          if (dual_wr) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = W_dstE;
            rf_wdata_d = W_valE;
            state_d    = ST_SECOND;
          end else if (m_vld) begin
            // Covers both M-only and same-destination (M wins, e.g. popq %rsp).
            rf_we_d    = 1'b1;
            rf_waddr_d = W_dstM;
            rf_wdata_d = W_valM;
          end else if (e_vld) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = W_dstE;
            rf_wdata_d = W_valE;
          end
        end
      end
      ST_SECOND: begin
        // W is held by the stall, so the M half is still on the inputs.
        rf_we_d    = 1'b1;
        rf_waddr_d = W_dstM;
        rf_wdata_d = W_valM;
        state_d    = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any pending second write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= RNONE;
      rf_wdata_q  <= '0;
      proc_stat_q <= SAOK;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      proc_stat_q <= proc_stat_d;
      halted_q    <= halted_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign proc_stat = proc_stat_q;
  assign halted    = halted_q;

`ifdef WB_PERF_CNT_EN
  logic             ret_inc, dual_inc;
  logic [CNT_W-1:0] retired_q, dual_stall_q;

  // An instruction retires when its last write issues: single-cycle in IDLE, or in SECOND.
  always_comb begin
    ret_inc  = ((state_q == ST_IDLE) && normal_op && !dual_wr) || (state_q == ST_SECOND);
    dual_inc = (state_q == ST_IDLE) && normal_op && dual_wr;
  end

  // Free-running wrap-around counters; they stop naturally in HALT since no event fires there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q    <= '0;
      dual_stall_q <= '0;
    end else begin
      if (ret_inc)  retired_q    <= retired_q + CNT_W'(1);
      if (dual_inc) dual_stall_q <= dual_stall_q + CNT_W'(1);
    end
  end

  assign retired_cnt    = retired_q;
  assign dual_stall_cnt = dual_stall_q;
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer: table-driven single-cycle vectors, hand sequences for
// dual write / reset-mid-dual / halt, and randomized instructions against a rule-level model.
// Counter checks are compiled only when WB_PERF_CNT_EN is defined.
module tb_wb_write_sequencer;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic [2:0]        W_stat;
  logic [3:0]        W_icode;
  logic              W_Cnd;
  logic [DATA_W-1:0] W_valE, W_valM;
  logic [3:0]        W_dstE, W_dstM;
  logic              W_stall, rf_we, halted;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        proc_stat;
`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0]  retired_cnt, dual_stall_cnt;
`endif

  wb_write_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .W_stat    (W_stat),
    .W_icode   (W_icode),
    .W_Cnd     (W_Cnd),
    .W_valE    (W_valE),
    .W_valM    (W_valM),
    .W_dstE    (W_dstE),
    .W_dstM    (W_dstM),
    .W_stall   (W_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .proc_stat (proc_stat),
    .halted    (halted)
`ifdef WB_PERF_CNT_EN
    ,
    .retired_cnt    (retired_cnt),
    .dual_stall_cnt (dual_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        stall;
    logic        wr;
    logic [3:0]  addr;
    logic [63:0] data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Model of the last written address/data, which rf_waddr/rf_wdata must hold.
  logic [3:0]  m_addr;
  logic [63:0] m_data;
  int unsigned exp_ret;
  int unsigned exp_dual;

  function automatic instr_t mk(input logic [2:0] st, input logic [3:0] ic, input logic c,
                                input logic [3:0] de, input logic [63:0] ve,
                                input logic [3:0] dm, input logic [63:0] vm);
    instr_t t;
    t.stat = st; t.icode = ic; t.cnd = c;
    t.dstE = de; t.valE = ve; t.dstM = dm; t.valM = vm;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input instr_t t);
    W_stat = t.stat; W_icode = t.icode; W_Cnd = t.cnd;
    W_valE = t.valE; W_valM = t.valM; W_dstE = t.dstE; W_dstM = t.dstM;
  endtask

  // Called at a falling edge with inputs applied: check stall, clock once, check rf outputs.
  task automatic cycle(input string nm, input logic stall_e, input logic wr,
                       input logic [3:0] a, input logic [63:0] d);
    #1;
    chk({nm, "_stall"}, 64'(W_stall), 64'(stall_e));
    @(posedge clk);
    @(negedge clk);
    if (wr) begin
      m_addr = a;
      m_data = d;
    end
    chk({nm, "_we"},    64'(rf_we),    64'(wr));
    chk({nm, "_waddr"}, 64'(rf_waddr), 64'(m_addr));
    chk({nm, "_wdata"}, rf_wdata,      m_data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_addr = 4'hF;
    m_data = '0;
    exp_ret = 0;
    exp_dual = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t   tbl[8];
  instr_t t;
  instr_t irm, popb, bub;
  logic [3:0]  wa[2];
  logic [63:0] wd[2];
  int          n;
  logic        e, m;

  initial begin
    tbl[0] = '{mk(3'd1, 4'h3, 1'b0, 4'h2, 64'h1234, 4'hF, 64'h0),   1'b0, 1'b1, 4'h2, 64'h1234};
    tbl[1] = '{mk(3'd1, 4'hB, 1'b0, 4'h4, 64'h108,  4'h4, 64'h77),  1'b0, 1'b1, 4'h4, 64'h77};
    tbl[2] = '{mk(3'd1, 4'h2, 1'b0, 4'h1, 64'h99,   4'hF, 64'h0),   1'b0, 1'b0, 4'h0, 64'h0};
    tbl[3] = '{mk(3'd1, 4'h2, 1'b1, 4'h1, 64'h99,   4'hF, 64'h0),   1'b0, 1'b1, 4'h1, 64'h99};
    tbl[4] = '{mk(3'd1, 4'h5, 1'b0, 4'hF, 64'h11,   4'h7, 64'h5555),1'b0, 1'b1, 4'h7, 64'h5555};
    tbl[5] = '{mk(3'd0, 4'h3, 1'b0, 4'h3, 64'h1,    4'h6, 64'h2),   1'b0, 1'b0, 4'h0, 64'h0};
    tbl[6] = '{mk(3'd1, 4'h1, 1'b0, 4'hF, 64'h3,    4'hF, 64'h4),   1'b0, 1'b0, 4'h0, 64'h0};
    tbl[7] = '{mk(3'd1, 4'h2, 1'b0, 4'h1, 64'h5,    4'h6, 64'h66),  1'b0, 1'b1, 4'h6, 64'h66};
    irm  = mk(3'd1, 4'h3, 1'b0, 4'h2, 64'h1234, 4'hF, 64'h0);
    popb = mk(3'd1, 4'hB, 1'b0, 4'h4, 64'h108,  4'h3, 64'hAB);
    bub  = mk(3'd0, 4'h0, 1'b0, 4'h5, 64'h9,    4'h6, 64'h8);

    apply(bub);
    do_reset();
    chk("rst_we",     64'(rf_we),     64'd0);
    chk("rst_waddr",  64'(rf_waddr),  64'hF);
    chk("rst_wdata",  rf_wdata,       64'd0);
    chk("rst_stat",   64'(proc_stat), 64'd1);
    chk("rst_halted", 64'(halted),    64'd0);
    chk("rst_stall",  64'(W_stall),   64'd0);

    // Single-cycle vectors, applied back to back.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].in);
      cycle($sformatf("tbl%0d", i), tbl[i].stall, tbl[i].wr, tbl[i].addr, tbl[i].data);
    end

    // popq %rbx: E write then M write, W held one extra cycle.
    apply(popb);
    cycle("popb_c1", 1'b1, 1'b1, 4'h4, 64'h108);
    cycle("popb_c2", 1'b0, 1'b1, 4'h3, 64'hAB);

    // Reset while in the second half of a dual write.
    apply(popb);
    cycle("rd_c1", 1'b1, 1'b1, 4'h4, 64'h108);
    rst_n = 1'b0;
    #1;
    chk("rd_we",    64'(rf_we),     64'd0);
    chk("rd_stall", 64'(W_stall),   64'd0);
    chk("rd_stat",  64'(proc_stat), 64'd1);
    chk("rd_waddr", 64'(rf_waddr),  64'hF);
    m_addr = 4'hF; m_data = '0; exp_ret = 0; exp_dual = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(3'd1, 4'h3, 1'b0, 4'h3, 64'h5, 4'hF, 64'h0));
    cycle("rd_single", 1'b0, 1'b1, 4'h3, 64'h5);
    exp_ret = 1;

    // Randomized normal/bubble stream against a rule-level model.
    for (int k = 0; k < 300; k++) begin
      t.stat  = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd1;
      t.icode = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 2) == 0) t.icode = 4'h2;
      t.cnd   = 1'($urandom_range(0, 1));
      t.dstM  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      case ($urandom_range(0, 3))
        0:       t.dstE = 4'hF;
        1:       t.dstE = t.dstM;
        default: t.dstE = 4'($urandom_range(0, 14));
      endcase
      t.valE = {$urandom, $urandom};
      t.valM = {$urandom, $urandom};

      n = 0; wa[0] = 4'h0; wd[0] = '0; wa[1] = 4'h0; wd[1] = '0;
      e = (t.dstE != 4'hF) && !(t.icode == 4'h2 && !t.cnd);
      m = (t.dstM != 4'hF);
      if (t.stat == 3'd1) begin
        exp_ret++;
        if (e && m && t.dstE == t.dstM) begin
          wa[0] = t.dstM; wd[0] = t.valM; n = 1;
        end else begin
          if (e) begin wa[n] = t.dstE; wd[n] = t.valE; n++; end
          if (m) begin wa[n] = t.dstM; wd[n] = t.valM; n++; end
        end
      end

      apply(t);
      if (n == 2) begin
        exp_dual++;
        cycle($sformatf("rnd%0d_a", k), 1'b1, 1'b1, wa[0], wd[0]);
        cycle($sformatf("rnd%0d_b", k), 1'b0, 1'b1, wa[1], wd[1]);
      end else begin
        cycle($sformatf("rnd%0d", k), 1'b0, (n == 1), wa[0], wd[0]);
      end
    end
`ifdef WB_PERF_CNT_EN
    chk("rnd_retired", 64'(retired_cnt),    64'(exp_ret));
    chk("rnd_dual",    64'(dual_stall_cnt), 64'(exp_dual));
`endif

    // irmovq, popq %rbx, bubble, then a halting entry followed by a valid irmovq.
    apply(bub);
    do_reset();
    apply(irm);
    cycle("seq_irm", 1'b0, 1'b1, 4'h2, 64'h1234);
    apply(popb);
    cycle("seq_pop1", 1'b1, 1'b1, 4'h4, 64'h108);
    cycle("seq_pop2", 1'b0, 1'b1, 4'h3, 64'hAB);
    apply(bub);
    cycle("seq_bub", 1'b0, 1'b0, 4'h0, 64'h0);
    apply(mk(3'd2, 4'h0, 1'b0, 4'h5, 64'h9, 4'hF, 64'h0));
    cycle("halt_entry", 1'b0, 1'b0, 4'h0, 64'h0);
    chk("halt_stat",   64'(proc_stat), 64'd2);
    chk("halt_halted", 64'(halted),    64'd1);
    apply(irm);
    for (int j = 0; j < 10; j++) begin
      cycle($sformatf("halt_hold%0d", j), 1'b1, 1'b0, 4'h0, 64'h0);
      chk($sformatf("halt_hold%0d_stat", j), 64'(proc_stat), 64'd2);
`ifdef WB_PERF_CNT_EN
      chk($sformatf("halt_hold%0d_ret", j),  64'(retired_cnt),    64'd2);
      chk($sformatf("halt_hold%0d_dual", j), 64'(dual_stall_cnt), 64'd1);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
